// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port unified memory between the fetch stage (instruction
//   reads) and the MEM stage (data loads/stores). Each access is a
//   request/ready handshake to memory, answered with a one-cycle ack and
//   registered read data. Per-port stall requests and a sticky timeout flag
//   are also produced.
//
//   Optional feature macro: ARB_RR_EN
//     defined   : round-robin between fetch and data on simultaneous requests
//     undefined : fixed priority, data port always wins
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | no access in flight; sample requests and grant one port
// S_GRANT_IF | fetch access on the memory bus, waiting for mem_ready/timeout
// S_GRANT_DM | data access on the memory bus, waiting for mem_ready/timeout
// S_DONE     | ack pulse to the granted port; requests are not sampled
//
// Ports
//   i_clk, i_rst_n                        clock, async active-low reset
//   i_if_req, i_if_addr                   fetch read request
//   o_if_ack, o_if_rdata                  fetch completion pulse and data
//   i_dm_req, i_dm_we, i_dm_addr,
//   i_dm_wdata                            data load/store request
//   o_dm_ack, o_dm_rdata                  data completion pulse and load data
//   o_mem_req, o_mem_we, o_mem_addr,
//   o_mem_wdata                           memory request side
//   i_mem_ready, i_mem_rdata              memory completion and read data
//   o_if_stall, o_dm_stall                stall requests toward stall_unit
//   o_bus_err                             sticky memory timeout flag
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_ack,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic              o_dm_ack,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_if_stall,
    output logic              o_dm_stall,
    output logic              o_bus_err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GRANT_IF = 2'd1,
        S_GRANT_DM = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    // Last counted cycle before the access is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic              r_if_ack;
    logic              r_dm_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_bus_err;
    logic              w_pick_dm;
    logic [DATA_W-1:0] w_rdata;

`ifdef ARB_RR_EN
    // 1 = data port got the most recent grant; reset value favours DM next.
    logic              r_last_dm;

    assign w_pick_dm = i_dm_req & (~i_if_req | ~r_last_dm);
`else
    assign w_pick_dm = i_dm_req;
`endif

    // Stores return zero data to the requester.
    assign w_rdata = r_mem_we ? '0 : i_mem_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_bus_err   <= 1'b0;
`ifdef ARB_RR_EN
            r_last_dm   <= 1'b0;
`endif
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_dm_req || i_if_req) begin
                        r_state     <= w_pick_dm ? S_GRANT_DM : S_GRANT_IF;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_pick_dm & i_dm_we;
                        r_mem_addr  <= w_pick_dm ? i_dm_addr : i_if_addr;
                        r_mem_wdata <= w_pick_dm ? i_dm_wdata : '0;
                        r_cnt       <= '0;
`ifdef ARB_RR_EN
                        r_last_dm   <= w_pick_dm;
`endif
                    end
                end
                S_GRANT_IF, S_GRANT_DM: begin
                    // Ready beats a coincident timeout.
                    if (i_mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_DONE;
                        if (r_state == S_GRANT_DM) begin
                            r_dm_ack   <= 1'b1;
                            r_dm_rdata <= w_rdata;
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= w_rdata;
                        end
                    end else if (r_cnt == TO_LAST) begin
                        r_mem_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= S_DONE;
                        if (r_state == S_GRANT_DM) begin
                            r_dm_ack   <= 1'b1;
                            r_dm_rdata <= '0;
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_if_ack    = r_if_ack;
    assign o_dm_ack    = r_dm_ack;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_bus_err   = r_bus_err;
    assign o_if_stall  = i_if_req & ~r_if_ack;
    assign o_dm_stall  = i_dm_req & ~r_dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        if_stall;
    logic        dm_stall;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_ack    (if_ack),
        .o_if_rdata  (if_rdata),
        .i_dm_req    (dm_req),
        .i_dm_we     (dm_we),
        .i_dm_addr   (dm_addr),
        .i_dm_wdata  (dm_wdata),
        .o_dm_ack    (dm_ack),
        .o_dm_rdata  (dm_rdata),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_ready (mem_ready),
        .i_mem_rdata (mem_rdata),
        .o_if_stall  (if_stall),
        .o_dm_stall  (dm_stall),
        .o_bus_err   (bus_err)
    );

    // Waits (bounded) for mem_req; returns positioned at the negedge where it is seen.
    task automatic wait_mem_req(output logic to);
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
        dm_addr = 0; dm_wdata = 0; mem_ready = 0; mem_rdata = 0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        checks++; if ({if_ack, dm_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks got %b exp 00", {if_ack, dm_ack}); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got %b exp 0", bus_err); end
        checks++; if ({if_rdata, dm_rdata} !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", {if_rdata, dm_rdata}); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_if_read;
        if_req = 1; if_addr = 32'h40;
        @(negedge clk); // cycle 1
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
            errors++; $display("FAIL ifrd_mem_bus got req=%b addr=%h we=%b exp 1 40 0", mem_req, mem_addr, mem_we); end
        checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL ifrd_stall got %b exp 1", if_stall); end
        @(negedge clk); // cycle 2
        @(negedge clk); // cycle 3
        checks++; if (if_ack !== 1'b0) begin errors++; $display("FAIL ifrd_early_ack got %b exp 0", if_ack); end
        mem_ready = 1; mem_rdata = 32'h1234;
        @(negedge clk); // cycle 4
        mem_ready = 0; mem_rdata = 0;
        checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h1234) begin
            errors++; $display("FAIL ifrd_ack got ack=%b data=%h exp 1 1234", if_ack, if_rdata); end
        checks++; if (dm_ack !== 1'b0 || mem_req !== 1'b0 || if_stall !== 1'b0) begin
            errors++; $display("FAIL ifrd_side got dm_ack=%b mem_req=%b stall=%b exp 0 0 0", dm_ack, mem_req, if_stall); end
        if_req = 0;
        @(negedge clk); // cycle 5, idle: stray ready must be ignored
        checks++; if (if_ack !== 1'b0) begin errors++; $display("FAIL ifrd_ack_len got %b exp 0", if_ack); end
        mem_ready = 1; mem_rdata = 32'hBAD;
        @(negedge clk);
        mem_ready = 0; mem_rdata = 0;
        checks++; if ({if_ack, dm_ack, mem_req} !== 3'b000 || if_rdata !== 32'h1234) begin
            errors++; $display("FAIL idle_ready got acks=%b req=%b data=%h exp 000 1234", {if_ack, dm_ack}, mem_req, if_rdata); end
    endtask

    task automatic test_store;
        dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hCAFE; mem_rdata = 32'hDEAD;
        @(negedge clk); // cycle 1
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hCAFE) begin
            errors++; $display("FAIL st_bus1 got req=%b we=%b addr=%h wd=%h exp 1 1 100 cafe", mem_req, mem_we, mem_addr, mem_wdata); end
        checks++; if (dm_stall !== 1'b1) begin errors++; $display("FAIL st_stall got %b exp 1", dm_stall); end
        @(negedge clk); // cycle 2
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hCAFE) begin
            errors++; $display("FAIL st_bus2 got req=%b we=%b wd=%h exp 1 1 cafe", mem_req, mem_we, mem_wdata); end
        mem_ready = 1;
        @(negedge clk); // cycle 3
        mem_ready = 0; mem_rdata = 0;
        checks++; if (dm_ack !== 1'b1 || dm_rdata !== 32'h0) begin
            errors++; $display("FAIL st_ack got ack=%b data=%h exp 1 0", dm_ack, dm_rdata); end
        checks++; if (if_ack !== 1'b0 || if_rdata !== 32'h1234) begin
            errors++; $display("FAIL st_other_port got ack=%b data=%h exp 0 1234", if_ack, if_rdata); end
        dm_req = 0; dm_we = 0;
        @(negedge clk);
        checks++; if (dm_ack !== 1'b0) begin errors++; $display("FAIL st_ack_len got %b exp 0", dm_ack); end
    endtask

    task automatic test_conflict;
        logic       to;
        logic [2:0] exp_dm;
        int         rem_if;
        int         rem_dm;
`ifdef ARB_RR_EN
        exp_dm = 3'b101; // bit k = access k goes to DM
`else
        exp_dm = 3'b011;
`endif
        rem_if = 1; rem_dm = 2;
        if_req = 1; if_addr = 32'h200;
        dm_req = 1; dm_we = 0; dm_addr = 32'h300;
        for (int k = 0; k < 3; k++) begin
            wait_mem_req(to);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL conf_wait%0d got timeout exp mem_req", k); end
            mem_ready = 1; mem_rdata = 32'h50 + 32'(k);
            @(negedge clk);
            mem_ready = 0; mem_rdata = 0;
            checks++; if (dm_ack !== exp_dm[k] || if_ack !== ~exp_dm[k]) begin
                errors++; $display("FAIL conf_order%0d got dm_ack=%b if_ack=%b exp %b %b", k, dm_ack, if_ack, exp_dm[k], ~exp_dm[k]); end
            if (dm_ack === 1'b1) begin
                checks++; if (dm_rdata !== 32'h50 + 32'(k)) begin
                    errors++; $display("FAIL conf_dm_data%0d got %h exp %h", k, dm_rdata, 32'h50 + 32'(k)); end
                rem_dm--;
                if (rem_dm == 0) dm_req = 0; else dm_addr = 32'h304;
            end
            if (if_ack === 1'b1) begin
                checks++; if (if_rdata !== 32'h50 + 32'(k)) begin
                    errors++; $display("FAIL conf_if_data%0d got %h exp %h", k, if_rdata, 32'h50 + 32'(k)); end
                rem_if--;
                if (rem_if == 0) if_req = 0;
            end
        end
        if_req = 0; dm_req = 0;
        @(negedge clk);
    endtask

    task automatic test_ready_last;
        logic to;
        if_req = 1; if_addr = 32'h44;
        wait_mem_req(to); // cycle 1
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rlast_wait got timeout exp mem_req"); end
        @(negedge clk); @(negedge clk); @(negedge clk); // cycle 4, last allowed cycle
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rlast_req got %b exp 1", mem_req); end
        mem_ready = 1; mem_rdata = 32'h77;
        @(negedge clk);
        mem_ready = 0; mem_rdata = 0;
        checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h77 || bus_err !== 1'b0) begin
            errors++; $display("FAIL rlast_ack got ack=%b data=%h err=%b exp 1 77 0", if_ack, if_rdata, bus_err); end
        if_req = 0;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        logic to;
        dm_req = 1; dm_we = 0; dm_addr = 32'h500; mem_rdata = 32'hBEEF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (mem_req !== 1'b1 || dm_ack !== 1'b0) begin
                errors++; $display("FAIL to_req_c%0d got req=%b ack=%b exp 1 0", c, mem_req, dm_ack); end
        end
        @(negedge clk); // cycle 5
        checks++; if (mem_req !== 1'b0 || dm_ack !== 1'b1 || dm_rdata !== 32'h0 || bus_err !== 1'b1) begin
            errors++; $display("FAIL to_abort got req=%b ack=%b data=%h err=%b exp 0 1 0 1", mem_req, dm_ack, dm_rdata, bus_err); end
        dm_req = 0; mem_rdata = 0;
        @(negedge clk);
        checks++; if (bus_err !== 1'b1 || dm_ack !== 1'b0) begin
            errors++; $display("FAIL to_sticky1 got err=%b ack=%b exp 1 0", bus_err, dm_ack); end
        if_req = 1; if_addr = 32'h60;
        wait_mem_req(to);
        mem_ready = 1; mem_rdata = 32'h66;
        @(negedge clk);
        mem_ready = 0; mem_rdata = 0;
        checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h66 || bus_err !== 1'b1) begin
            errors++; $display("FAIL to_sticky2 got ack=%b data=%h err=%b exp 1 66 1", if_ack, if_rdata, bus_err); end
        if_req = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic to;
        dm_req = 1; dm_we = 1; dm_addr = 32'h600; dm_wdata = 32'h1;
        wait_mem_req(to);
        @(negedge clk); // still in GRANT_DM
        rst_n = 0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || dm_ack !== 1'b0 || bus_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got req=%b we=%b ack=%b err=%b exp 0 0 0 0", mem_req, mem_we, dm_ack, bus_err); end
        dm_req = 0; dm_we = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++; if (dm_ack !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle got ack=%b req=%b exp 0 0", dm_ack, mem_req); end
        if_req = 1; if_addr = 32'h48;
        wait_mem_req(to);
        checks++; if (to !== 1'b0 || mem_addr !== 32'h48) begin
            errors++; $display("FAIL rstmid_grant got to=%b addr=%h exp 0 48", to, mem_addr); end
        mem_ready = 1; mem_rdata = 32'h99;
        @(negedge clk);
        mem_ready = 0; mem_rdata = 0;
        checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h99 || dm_ack !== 1'b0) begin
            errors++; $display("FAIL rstmid_fresh got ack=%b data=%h dm_ack=%b exp 1 99 0", if_ack, if_rdata, dm_ack); end
        if_req = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_if_read;
        test_store;
        test_conflict;
        test_ready_last;
        test_timeout;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion exp finish");
        $fatal(1, "watchdog");
    end

endmodule
